aes_enc_ctrl: RTL and testbench

Iterative AES encryption round controller. It accepts one 128-bit plaintext block over a valid/ready handshake and sequences the team's combinational round datapath (subBytes, shiftRows, mixColumns, AddRoundKey XOR) once per clock. It fetches round keys from the key-schedule store through an index/data port and returns the ciphertext over a second valid/ready handshake. It sits between the TLS record-layer framer and the key-expansion block.

---
 rtl/aes_enc_ctrl_if.sv | 22 ++
 rtl/aes_enc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_aes_enc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_enc_ctrl_if.sv
// Plaintext/ciphertext valid-ready handshakes and the round-key fetch port of aes_enc_ctrl.
// slave is the controller side; master is the framer/key-store side.
interface aes_enc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_enc_ctrl.sv
// Iterative AES encryption round controller: one round per clock, round keys fetched by index,
// state kept row-major internally and transposed to FIPS-197 column-major order at the ports.
module aes_enc_ctrl #(
  parameter int ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          busy,
  aes_enc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Swaps row-major and column-major byte order; the mapping is its own inverse.
  function automatic logic [127:0] transpose(input logic [127:0] s);
    logic [127:0] t;
    t = 128'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127-32*r-8*c -: 8] = s[127-32*c-8*r -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] t;
    t = 128'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127-32*r-8*c -: 8] = sbox(s[127-32*r-8*((c+r)%4) -: 8]);
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*c -: 8];
      a1 = s[95-8*c -: 8];
      a2 = s[63-8*c -: 8];
      a3 = s[31-8*c -: 8];
      t[127-8*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[95-8*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[63-8*c -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[31-8*c -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_row_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;

  assign rk_row_s = transpose(bus.rk_data);
  assign sr_s     = sub_shift(blk_q);
  assign mc_s     = mix_columns(sr_s);

  // Handshake/status outputs decode registered state only; nothing combinational from inputs.
  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign busy          = (fsm_q == ROUND) || (fsm_q == DONE);
  assign bus.rk_idx    = (fsm_q == ROUND) ? rnd_q : 4'd0;
  assign bus.out_data  = transpose(blk_q);

  // Next-state, round counter and datapath state update.
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    blk_d = blk_q;
    if (flush) begin
      fsm_d = IDLE;
      rnd_d = 4'd0;
      blk_d = 128'd0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.in_valid) begin
            blk_d = transpose(bus.in_data) ^ rk_row_s;
            rnd_d = 4'd1;
            fsm_d = ROUND;
          end else begin
            fsm_d = IDLE;
          end
        end
        ROUND: begin
          // Counter is cleared after the last round so it never exceeds ROUNDS.
          if (rnd_q >= LAST_RND) begin
            blk_d = sr_s ^ rk_row_s;
            rnd_d = 4'd0;
            fsm_d = DONE;
          end else begin
            blk_d = mc_s ^ rk_row_s;
            rnd_d = rnd_q + 4'd1;
            fsm_d = ROUND;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_d = IDLE;
          end else begin
            fsm_d = DONE;
          end
        end
        default: begin
          fsm_d = IDLE;
          rnd_d = 4'd0;
          blk_d = 128'd0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= 4'd0;
      blk_q <= 128'd0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      blk_q <= blk_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl: FIPS-197 C.1 vectors through a scoreboard queue,
// back-pressure, busy-input, flush, async reset and back-to-back scenarios.
module tb_aes_enc_ctrl;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;
  logic [127:0] exp_q [$];
  logic [127:0] rk_tbl [0:10];

  aes_enc_ctrl_if bus ();

  aes_enc_ctrl #(.ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Key store: combinational lookup of the C.1 expanded schedule.
  assign bus.rk_data = (bus.rk_idx <= 4'd10) ? rk_tbl[bus.rk_idx] : 128'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 128'bx;
    return exp_q.pop_front();
  endfunction

  // Offers pt, pushes its expected ciphertext at the accept edge, then waits for out_valid.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp,
                           output int lat, output bit ok);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    while (!bus.in_ready && guard < 30) begin
      step();
      guard++;
    end
    step();
    bus.in_valid = 1'b0;
    exp_q.push_back(exp);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 128'd0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (bus.rk_idx !== 4'd0) begin miscompares++; $display("FAIL rst_rk_idx: got %0d want 0", bus.rk_idx); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips_c1();
    logic [127:0] e;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = PT;
    vectors++; if (bus.rk_idx !== 4'd0) begin miscompares++; $display("FAIL c1_rk_idx_idle: got %0d want 0", bus.rk_idx); end
    step();
    bus.in_valid = 1'b0;
    exp_q.push_back(CT);
    for (int r = 1; r <= 10; r++) begin
      vectors++; if (bus.rk_idx !== 4'(r)) begin miscompares++; $display("FAIL c1_rk_idx: got %0d want %0d", bus.rk_idx, r); end
      vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL c1_round_status r%0d: got valid=%b busy=%b want 0/1", r, bus.out_valid, busy); end
      step();
    end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL c1_latency: got out_valid=%b want 1 at 10 cycles", bus.out_valid); end
    vectors++; if (bus.rk_idx !== 4'd0 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL c1_done_status: got rk_idx=%0d in_ready=%b want 0/0", bus.rk_idx, bus.in_ready); end
    e = pop_exp();
    vectors++; if (bus.out_data !== e) begin miscompares++; $display("FAIL c1_ct: got %h want %h", bus.out_data, e); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL c1_return_idle: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_back_pressure();
    int lat;
    bit ok;
    run_block(PT, CT, lat, ok);
    vectors++; if (!ok || lat != 10) begin miscompares++; $display("FAIL bp_latency: got ok=%b lat=%0d want 1/10", ok, lat); end
    for (int i = 0; i < 20; i++) begin
      vectors++; if (bus.out_data !== CT) begin miscompares++; $display("FAIL bp_hold_data: got %h want %h", bus.out_data, CT); end
      vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_status: got in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid); end
      step();
    end
    vectors++; if (bus.out_data !== pop_exp()) begin miscompares++; $display("FAIL bp_ct: got %h want %h", bus.out_data, CT); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got in_ready=%b want 1", bus.in_ready); end
  endtask

  task automatic test_busy_ignored();
    int lat;
    int extra;
    bus.in_valid = 1'b1;
    bus.in_data  = PT;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL busy_pre_idle: got in_ready=%b want 1", bus.in_ready); end
    step();
    exp_q.push_back(CT);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL busy_latency: got %0d want 10", lat); end
    vectors++; if (bus.out_data !== pop_exp()) begin miscompares++; $display("FAIL busy_ct: got %h want %h", bus.out_data, CT); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      extra += int'(bus.out_valid);
      step();
    end
    vectors++; if (extra != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL busy_second_output: got %0d extra valid cycles busy=%b want 0/0", extra, busy); end
  endtask

  task automatic test_flush();
    int guard;
    int seen;
    int lat;
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_data  = PT;
    step();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.rk_idx !== 4'd5 && guard < 20) begin
      step();
      guard++;
    end
    vectors++; if (bus.rk_idx !== 4'd5) begin miscompares++; $display("FAIL flush_reach_rnd5: got rk_idx=%0d want 5", bus.rk_idx); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_status: got busy=%b in_ready=%b want 0/1", busy, bus.in_ready); end
    vectors++; if (bus.rk_idx !== 4'd0) begin miscompares++; $display("FAIL flush_rk_idx: got %0d want 0", bus.rk_idx); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      seen += int'(bus.out_valid);
      step();
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL flush_no_output: got %0d valid cycles want 0", seen); end
    flush = 1'b1;
    bus.in_valid = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    vectors++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_masks_accept: got busy=%b in_ready=%b want 0/1", busy, bus.in_ready); end
    run_block(PT, CT, lat, ok);
    vectors++; if (!ok || lat != 10) begin miscompares++; $display("FAIL flush_after_latency: got ok=%b lat=%0d want 1/10", ok, lat); end
    vectors++; if (bus.out_data !== pop_exp()) begin miscompares++; $display("FAIL flush_after_ct: got %h want %h", bus.out_data, CT); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat;
    int seen;
    bit ok;
    run_block(PT, CT, lat, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL arst_reach_done: got out_valid=%b want 1", ok); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 128'd0) begin miscompares++; $display("FAIL arst_out_data: got %h want 0", bus.out_data); end
    vectors++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_status: got busy=%b in_ready=%b want 0/1", busy, bus.in_ready); end
    exp_q.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = PT;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_input_ignored: got busy=%b want 0", busy); end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    run_block(PT, CT, lat, ok);
    vectors++; if (!ok || lat != 10) begin miscompares++; $display("FAIL arst_after_latency: got ok=%b lat=%0d want 1/10", ok, lat); end
    vectors++; if (bus.out_data !== pop_exp()) begin miscompares++; $display("FAIL arst_after_ct: got %h want %h", bus.out_data, CT); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      seen += int'(bus.out_valid);
      step();
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL arst_single_output: got %0d extra valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n_acc;
    int n_out;
    int acc_t [3];
    logic [127:0] e;
    cyc = 0;
    n_acc = 0;
    n_out = 0;
    acc_t = '{0, 0, 0};
    bus.in_valid  = 1'b1;
    bus.in_data   = PT;
    bus.out_ready = 1'b1;
    while (n_out < 3 && cyc < 80) begin
      if (bus.in_ready && bus.in_valid) begin
        if (n_acc < 3) acc_t[n_acc] = cyc;
        n_acc++;
        exp_q.push_back(CT);
      end
      if (bus.out_valid) begin
        e = pop_exp();
        vectors++; if (bus.out_data !== e) begin miscompares++; $display("FAIL b2b_ct%0d: got %h want %h", n_out, bus.out_data, e); end
        n_out++;
        if (n_out == 3) bus.in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    vectors++; if (n_out != 3 || n_acc != 3) begin miscompares++; $display("FAIL b2b_counts: got %0d outputs %0d accepts want 3/3", n_out, n_acc); end
    vectors++; if (acc_t[1] - acc_t[0] != 12) begin miscompares++; $display("FAIL b2b_spacing01: got %0d want 12", acc_t[1] - acc_t[0]); end
    vectors++; if (acc_t[2] - acc_t[1] != 12) begin miscompares++; $display("FAIL b2b_spacing12: got %0d want 12", acc_t[2] - acc_t[1]); end
    step();
    vectors++; if (busy !== 1'b0 || exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got busy=%b pending=%0d want 0/0", busy, exp_q.size()); end
  endtask

  initial begin
    rk_tbl[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_tbl[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_tbl[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_tbl[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_tbl[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_tbl[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_tbl[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_tbl[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_tbl[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_tbl[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_tbl[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 128'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips_c1();
    test_back_pressure();
    test_busy_ignored();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
